// File: rtl/int_img_stream.sv
// Streaming integral-image engine: one pixel in, one (ii, squared ii) result out per handshake.
// Uses a single line buffer of the previous row's integral values instead of a full frame store.
module int_img_stream #(
   parameter int WIDTH = 40,
   parameter int HEIGHT = 30,
   parameter int PIX_W = 8,
   parameter int SUM_W = 32,
   parameter int SQ_EN = 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   input  logic             in_sof,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SUM_W-1:0] out_ii,
   output logic [SUM_W-1:0] out_sq,
   output logic             out_sof,
   output logic             out_eof,
   output logic             sync_err
);

   localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

   logic [XW-1:0]    x_reg, x_eff, x_next, rd_addr;
   logic [YW-1:0]    y_reg, y_eff, y_next;
   logic             accept, restart, row_last, frame_last;
   logic             out_valid_reg, out_sof_reg, out_eof_reg, sync_err_reg;
   logic [SUM_W-1:0] out_ii_reg, out_sq_reg;
   logic [SUM_W-1:0] row_sum_reg, rs, above, ii, iq;
   logic [SUM_W-1:0] lb [0:WIDTH-1];
   logic [SUM_W-1:0] lb_rd_reg;

   assign in_ready  = !out_valid_reg || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_reg;
   assign out_ii    = out_ii_reg;
   assign out_sq    = out_sq_reg;
   assign out_sof   = out_sof_reg;
   assign out_eof   = out_eof_reg;
   assign sync_err  = sync_err_reg;

   // A misplaced start-of-frame resynchronises: the pixel is handled as if it were at (0,0).
   always_comb begin
      restart    = in_sof && ((x_reg != '0) || (y_reg != '0));
      x_eff      = restart ? '0 : x_reg;
      y_eff      = restart ? '0 : y_reg;
      row_last   = (x_eff == X_LAST);
      frame_last = row_last && (y_eff == Y_LAST);
      x_next     = row_last ? '0 : x_eff + 1'b1;
      if (!row_last)
         y_next = y_eff;
      else if (y_eff == Y_LAST)
         y_next = '0;
      else
         y_next = y_eff + 1'b1;
      // Prefetch the line-buffer entry for the position that will be processed next.
      rd_addr = accept ? x_next : x_reg;
   end

   always_comb begin
      rs    = ((x_eff == '0) ? '0 : row_sum_reg) + SUM_W'(in_pix);
      above = (y_eff == '0) ? '0 : lb_rd_reg;
      ii    = rs + above;
   end

   // Write address (x_eff) never equals the prefetch address (x_next) on an accept, since WIDTH >= 2.
   always_ff @(posedge clock) begin
      if (accept)
         lb[x_eff] <= ii;
      lb_rd_reg <= lb[rd_addr];
   end

   generate
      if (SQ_EN != 0) begin : g_sq
         logic [2*PIX_W-1:0] sq;
         logic [SUM_W-1:0]   row_sq_reg, rq, above_q;
         logic [SUM_W-1:0]   lbq [0:WIDTH-1];
         logic [SUM_W-1:0]   lbq_rd_reg;

         always_comb begin
            sq      = in_pix * in_pix;
            rq      = ((x_eff == '0) ? '0 : row_sq_reg) + SUM_W'(sq);
            above_q = (y_eff == '0) ? '0 : lbq_rd_reg;
            iq      = rq + above_q;
         end

         always_ff @(posedge clock) begin
            if (accept)
               lbq[x_eff] <= iq;
            lbq_rd_reg <= lbq[rd_addr];
         end

         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n)
               row_sq_reg <= '0;
            else if (accept)
               row_sq_reg <= rq;
         end
      end else begin : g_no_sq
         assign iq = '0;
      end
   endgenerate

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         x_reg       <= '0;
         y_reg       <= '0;
         row_sum_reg <= '0;
      end else if (accept) begin
         x_reg       <= x_next;
         y_reg       <= y_next;
         row_sum_reg <= rs;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         sync_err_reg <= 1'b0;
      else if (accept && restart)
         sync_err_reg <= 1'b1;
   end

   // Single output stage; data only changes on an accept, so it holds during backpressure.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_reg <= 1'b0;
         out_ii_reg    <= '0;
         out_sq_reg    <= '0;
         out_sof_reg   <= 1'b0;
         out_eof_reg   <= 1'b0;
      end else if (accept) begin
         out_valid_reg <= 1'b1;
         out_ii_reg    <= ii;
         out_sq_reg    <= iq;
         out_sof_reg   <= (x_eff == '0) && (y_eff == '0);
         out_eof_reg   <= frame_last;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_int_img_stream.sv
// Randomised scoreboard bench for int_img_stream on a 4x3 frame; the reference model
// keeps the frame's pixels and sums rectangles directly.
module tb_int_img_stream;

   localparam int W  = 4;
   localparam int H  = 3;
   localparam int PW = 8;
   localparam int SW = 32;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [PW-1:0] in_pix = '0;
   logic          in_sof = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [SW-1:0] out_ii, out_sq;
   logic          out_sof, out_eof, sync_err;

   always #5 clock = ~clock;

   int_img_stream #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .SUM_W(SW), .SQ_EN(1)) dut (
      .clock(clock), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix), .in_sof(in_sof),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ii(out_ii), .out_sq(out_sq), .out_sof(out_sof), .out_eof(out_eof),
      .sync_err(sync_err)
   );

   typedef struct packed {
      logic [31:0] ii;
      logic [31:0] sq;
      logic        sof;
      logic        eof;
      logic        serr;
   } exp_t;

   exp_t exp_q[$];
   int   img[H][W];
   int   mx = 0, my = 0;
   logic m_serr = 1'b0;
   int   n_checks = 0, n_fail = 0;
   bit   bp_rand = 0, bp_force = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference: integral = plain sum over the rectangle (0,0)..(x,y) of the current frame.
   function automatic exp_t model(input int p, input bit sof);
      exp_t e;
      logic [31:0] s, q;
      if (sof && (mx != 0 || my != 0)) begin
         m_serr = 1'b1;
         mx = 0;
         my = 0;
      end
      img[my][mx] = p;
      s = 0;
      q = 0;
      for (int j = 0; j <= my; j++)
         for (int i = 0; i <= mx; i++) begin
            s += img[j][i];
            q += img[j][i] * img[j][i];
         end
      e.ii   = s;
      e.sq   = q;
      e.sof  = (mx == 0 && my == 0);
      e.eof  = (mx == W - 1 && my == H - 1);
      e.serr = m_serr;
      mx++;
      if (mx == W) begin
         mx = 0;
         my = (my == H - 1) ? 0 : my + 1;
      end
      return e;
   endfunction

   // Called at a negedge; returns at the negedge following the accepting posedge.
   task automatic send(input int p, input bit sof, output int waits);
      in_valid = 1'b1;
      in_pix   = PW'(p);
      in_sof   = sof;
      waits    = 0;
      #1;
      while (!in_ready) begin
         @(negedge clock);
         #1;
         waits++;
         if (waits > 200) begin
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", waits);
            $fatal(1, "in_ready stuck low");
         end
      end
      exp_q.push_back(model(p, sof));
      @(negedge clock);
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int kind, input int val, input bit check_gapless);
      int waits;
      int p;
      for (int k = 0; k < W * H; k++) begin
         case (kind)
            0: p = val;
            1: p = k;
            default: p = int'($urandom_range(0, 255));
         endcase
         send(p, (k == 0), waits);
         if (check_gapless) chk("no_bubble_waits", waits, 0);
      end
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clock);
         n++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   always @(posedge clock) begin
      #2;
      if (!bp_force) out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Monitor: pop the scoreboard on every transfer, check holds under backpressure.
   logic        held = 1'b0;
   logic [65:0] held_val;
   always @(negedge clock) begin
      if (reset_n) begin
         chk("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (held) begin
            chk("hold_valid", out_valid, 1'b1);
            chk("hold_data", {out_ii, out_sq, out_sof, out_eof}, held_val);
         end
         held = 1'b0;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_output", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("out_ii", out_ii, e.ii);
               chk("out_sq", out_sq, e.sq);
               chk("out_sof", out_sof, e.sof);
               chk("out_eof", out_eof, e.eof);
               chk("sync_err", sync_err, e.serr);
            end
         end else if (out_valid) begin
            held     = 1'b1;
            held_val = {out_ii, out_sq, out_sof, out_eof};
         end
      end
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_ii"}, out_ii, 0);
      chk({tag, "_out_sq"}, out_sq, 0);
      chk({tag, "_out_sof"}, out_sof, 0);
      chk({tag, "_out_eof"}, out_eof, 0);
      chk({tag, "_sync_err"}, sync_err, 0);
      chk({tag, "_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int waits;
      repeat (2) @(negedge clock);
      #1;
      check_reset_state("reset");
      @(negedge clock);
      reset_n = 1'b1;

      // Constant frames and ramp with continuous ready.
      send_frame(0, 1, 1'b0);
      send_frame(0, 255, 1'b0);
      send_frame(1, 0, 1'b0);
      drain();

      // Three-cycle downstream stall mid-row.
      fork
         send_frame(0, 1, 1'b0);
         begin
            repeat (5) @(posedge clock);
            #2;
            bp_force  = 1'b1;
            out_ready = 1'b0;
            @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            repeat (3) @(posedge clock);
            #2;
            out_ready = 1'b1;
            bp_force  = 1'b0;
         end
      join
      drain();

      // Back-to-back frames; every pixel must be accepted on its first cycle.
      send_frame(0, 1, 1'b1);
      send_frame(0, 2, 1'b1);
      drain();

      // Misplaced start-of-frame on pixel 6.
      for (int k = 0; k < W * H; k++) send(k + 3, (k == 0 || k == 6), waits);
      drain();
      chk("sync_err_sticky", sync_err, 1);

      // Reset mid-frame, then a fresh frame must start at (0,0).
      for (int k = 0; k < 5; k++) send(7, (k == 0), waits);
      drain();
      reset_n = 1'b0;
      #1;
      check_reset_state("midreset");
      mx = 0;
      my = 0;
      m_serr = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) send(9 + k, 1'b0, waits);
      send_frame(2, 0, 1'b0);
      drain();

      // Random pixels with random input gaps and random backpressure.
      bp_rand = 1;
      for (int f = 0; f < 6; f++) begin
         for (int k = 0; k < W * H; k++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clock);
            send(int'($urandom_range(0, 255)), (k == 0) && ($urandom_range(0, 1) == 1), waits);
         end
      end
      drain();
      bp_rand = 0;

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
